// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state encoding
// and the default operand width.
package cmp_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/bit_idx_cnt.sv
// Loadable down counter used as the bit index of the serial compare.
// The zero flag is registered alongside the count so both change on the same edge.
module bit_idx_cnt #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] cnt,
    output logic          zero
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          zero_q;
    logic          zero_d;

    // Next count: load wins over decrement; decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != {CW{1'b0}})) begin
            cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
        zero_d = (cnt_d == {CW{1'b0}});
    end

    // Count and zero-flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= {CW{1'b0}};
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = zero_q;

endmodule

// File: rtl/serial_mag_cmp_ctrl.sv
// Serial unsigned magnitude comparator: one bit per cycle, MSB first, with early
// exit on the first differing bit and a start/busy/done handshake.
module serial_mag_cmp_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             g,
    output logic             l,
    output logic             e
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] IDX_MSB = CW'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sa_d;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] sb_d;
    logic             g_q;
    logic             g_d;
    logic             l_q;
    logic             l_d;
    logic             e_q;
    logic             e_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;

    logic             idx_load_s;
    logic             idx_dec_s;
    logic [CW-1:0]    idx_s;
    logic             idx_zero_s;

    bit_idx_cnt #(
        .CW (CW)
    ) u_idx (
        .clk      (clk),
        .rst      (rst),
        .load     (idx_load_s),
        .dec      (idx_dec_s),
        .load_val (IDX_MSB),
        .cnt      (idx_s),
        .zero     (idx_zero_s)
    );

    // Next-state and datapath control; the unused 2'b11 encoding behaves as IDLE.
    always_comb begin
        state_d    = state_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        g_d        = g_q;
        l_d        = l_q;
        e_d        = e_q;
        idx_load_s = 1'b0;
        idx_dec_s  = 1'b0;
        case (state_q)
            SHIFT: begin
                if (sa_q[WIDTH-1] && !sb_q[WIDTH-1]) begin
                    g_d     = 1'b1;
                    state_d = DONE;
                end else if (!sa_q[WIDTH-1] && sb_q[WIDTH-1]) begin
                    l_d     = 1'b1;
                    state_d = DONE;
                end else if (idx_zero_s) begin
                    e_d     = 1'b1;
                    state_d = DONE;
                end else begin
                    sa_d      = {sa_q[WIDTH-2:0], 1'b0};
                    sb_d      = {sb_q[WIDTH-2:0], 1'b0};
                    idx_dec_s = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                if (start) begin
                    sa_d       = a;
                    sb_d       = b;
                    g_d        = 1'b0;
                    l_d        = 1'b0;
                    e_d        = 1'b0;
                    idx_load_s = 1'b1;
                    state_d    = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
        // busy/done are registered from the next state so they line up with state_q.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, operand shift registers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sa_q    <= {WIDTH{1'b0}};
            sb_q    <= {WIDTH{1'b0}};
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            g_q     <= g_d;
            l_q     <= l_d;
            e_q     <= e_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign g    = g_q;
    assign l    = l_q;
    assign e    = e_q;

endmodule

// File: tb/tb_serial_mag_cmp_ctrl.sv
// Scoreboard bench for serial_mag_cmp_ctrl: directed compares push expected
// result and latency; a negedge monitor checks each done pulse against the queue.
module tb_serial_mag_cmp_ctrl;

    localparam int W = 8;

    typedef struct {
        logic g;
        logic l;
        logic e;
        int   n;
        int   acc;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         g;
    logic         l;
    logic         e;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb_q[$];

    serial_mag_cmp_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .g     (g),
        .l     (l),
        .e     (e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop and compare on every done; results must stay 0 during SHIFT.
    always @(negedge clk) begin
        exp_t x;
        if (done) begin
            checks = checks + 1;
            if (sb_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_done: got done=1 with no compare pending, required none");
            end else begin
                x = sb_q.pop_front();
                if ({g, l, e} !== {x.g, x.l, x.e}) begin
                    errors = errors + 1;
                    $display("FAIL result: got g/l/e=%b%b%b required %b%b%b", g, l, e, x.g, x.l, x.e);
                end
                checks = checks + 1;
                if ((cyc - x.acc) != x.n) begin
                    errors = errors + 1;
                    $display("FAIL latency: got %0d edges required %0d", cyc - x.acc, x.n);
                end
            end
        end else if (busy) begin
            checks = checks + 1;
            if ({g, l, e} !== 3'b000) begin
                errors = errors + 1;
                $display("FAIL shift_zero: got g/l/e=%b%b%b required 000", g, l, e);
            end
        end
    end

    task automatic chk(input string name, input logic [4:0] got, input logic [4:0] req);
        checks = checks + 1;
        if (got !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got busy/done/g/l/e=%b required %b", name, got, req);
        end
    endtask

    task automatic push_exp(input logic eg, input logic el, input logic ee, input int n);
        exp_t x;
        x.g = eg; x.l = el; x.e = ee; x.n = n; x.acc = cyc;
        sb_q.push_back(x);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !busy) break;
        end
        checks = checks + 1;
        if (!(sb_q.size() == 0 && !busy)) begin
            errors = errors + 1;
            $display("FAIL %s_timeout: got pending=%0d busy=%b required 0 and 0", name, sb_q.size(), busy);
        end
    endtask

    task automatic do_cmp(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic eg, input logic el, input logic ee, input int n);
        @(negedge clk);
        a = va; b = vb; start = 1'b1;
        @(posedge clk); #1;
        push_exp(eg, el, ee, n);
        @(negedge clk);
        start = 1'b0;
        wait_idle(name);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) begin
            @(negedge clk);
            chk("reset", {busy, done, g, l, e}, 5'b00000);
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle", {busy, done, g, l, e}, 5'b00000);
        end

        do_cmp("msb_exit", 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1);
        chk("hold_g", {busy, done, g, l, e}, 5'b00100);
        do_cmp("late_diff", 8'h12, 8'h13, 1'b0, 1'b1, 1'b0, 8);

        // Equal operands with a changed after acceptance.
        @(negedge clk);
        a = 8'hA5; b = 8'hA5; start = 1'b1;
        @(posedge clk); #1;
        push_exp(1'b0, 1'b0, 1'b1, 8);
        @(negedge clk);
        start = 1'b0; a = 8'h00;
        wait_idle("equal");
        chk("hold_e", {busy, done, g, l, e}, 5'b00001);

        // Start held high: dropped while busy and at done, accepted the cycle after.
        @(negedge clk);
        a = 8'h40; b = 8'h20; start = 1'b1;
        @(posedge clk); #1;
        push_exp(1'b1, 1'b0, 1'b0, 2);
        @(negedge clk);
        a = 8'h03; b = 8'h05;
        repeat (3) @(posedge clk);
        #1;
        chk("drop_at_done", {busy, done, g, l, e}, 5'b00100);
        @(posedge clk); #1;
        push_exp(1'b0, 1'b1, 1'b0, 6);
        chk("b2b_accept", {busy, done, g, l, e}, 5'b10000);
        @(negedge clk);
        start = 1'b0;
        wait_idle("b2b");
        chk("hold_l", {busy, done, g, l, e}, 5'b00010);

        // Reset mid-compare aborts without done.
        @(negedge clk);
        a = 8'h01; b = 8'h00; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_reset", {busy, done, g, l, e}, 5'b00000);
        @(negedge clk);
        chk("mid_reset_hold", {busy, done, g, l, e}, 5'b00000);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset", {busy, done, g, l, e}, 5'b00000);
        do_cmp("after_reset", 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8);
        repeat (3) @(negedge clk);
        chk("final_idle", {busy, done, g, l, e}, 5'b00100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_mag_cmp_ctrl.md
Name: serial_mag_cmp_ctrl

Overview:
- Sequential controller that compares two WIDTH-bit unsigned words one bit per cycle, MSB first.
- Exits early on the first differing bit.
- Reports greater/less/equal through a start/busy/done handshake.
- Sits beside the single-bit magnitude comparator and mod-8 counter datapath. It shares one 1-bit compare across a multi-bit operand, with a counter as the bit index.

Parameters:
- WIDTH, 8, operand width in bits; legal range is WIDTH >= 2.
- CW, $clog2(WIDTH), bit-index counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- start  input  1  request pulse; accepted only when busy=0.
- a  input  WIDTH  operand A, unsigned; sampled on the accept edge only.
- b  input  WIDTH  operand B, unsigned; sampled on the accept edge only.
- busy  output  1  high while state != IDLE.
- done  output  1  one-cycle pulse marking valid g/l/e.
- g  output  1  A > B.
- l  output  1  A < B.
- e  output  1  A == B.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; shift registers and counter cleared.
  - busy, done, g, l, e all 0.
  - Reset asserted mid-compare aborts the compare; no done is produced.
- FSM states: IDLE, SHIFT, DONE. busy = (state != IDLE).
- IDLE:
  - start=1 accepts: load sa<=a, sb<=b, idx<=WIDTH-1; clear g, l, e; next state SHIFT.
  - start=0: stay in IDLE.
- SHIFT, step k (k = 0..WIDTH-1), examines sa[MSB] vs sb[MSB]:
  - sa[MSB]=1, sb[MSB]=0: g<=1; next DONE.
  - sa[MSB]=0, sb[MSB]=1: l<=1; next DONE.
  - Bits equal and idx==0: e<=1; next DONE.
  - Bits equal and idx!=0: shift sa and sb left by 1 (zero fill), idx<=idx-1; stay in SHIFT.
- DONE: done=1 for exactly this one cycle; next state IDLE.
- Result outputs:
  - Exactly one of g/l/e is 1 from the DONE cycle onward.
  - They hold until the next accepted start clears them.
  - All three are 0 while SHIFT is in progress.
- Latency:
  - Let edge E0 be the edge that accepts start.
  - done is high after edge E0+N, where N = (index from MSB of the first differing bit, 0-based) + 1.
  - N = WIDTH when the operands are equal.
  - Range: 1..WIDTH.
- start while busy (SHIFT or DONE): ignored, not queued.
  - A start coincident with done is dropped.
  - Back-to-back throughput therefore needs start in the cycle after done.
- Operand changes on a/b after acceptance have no effect.
- Comparison is unsigned; the counter never wraps because SHIFT exits at idx==0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package cmp_pkg:
  - state encoding: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10; 2'b11 decodes to IDLE.
  - default WIDTH constant.
- One natural sub-module: bit_idx_cnt, a loadable CW-bit down counter with zero flag.
  - Ports: clk, rst, load, dec, load_val, cnt, zero.
- Shift registers and the FSM stay in serial_mag_cmp_ctrl.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then start=0 -> busy=0, done=0, g=l=e=0 throughout.
- Early exit on MSB: WIDTH=8, a=8'h80, b=8'h7F, start pulse -> done after 1 edge with g=1, l=0, e=0.
- Late difference: a=8'h12, b=8'h13 -> done after 8 edges (first difference at bit 0) with l=1.
- Equal operands: a=b=8'hA5 -> done after 8 edges with e=1.
  - Change a to 8'h00 during SHIFT -> result still e=1.
- Ignored start and back-to-back:
  - start held high through a compare of a=8'h40, b=8'h20 -> single done after 2 edges with g=1.
  - The start coincident with done is dropped.
  - The start in the cycle after done begins a new compare; g/l/e read 0 until the next done.
- Reset mid-operation: a=8'h01, b=8'h00, assert rst=0 at SHIFT step 3 -> immediately busy=0, all outputs 0, no done.
  - After release, a fresh start completes normally with g=1 after 8 edges.
